fpu_share_arbiter: RTL and testbench

- Shares one fixed-latency pipelined single-precision FPU execution unit (add/sub/mul/min-max class) between NUM_REQ requesters.
- Round-robin issue, at most one operation per cycle.
- Carries requester IDs alongside the unit's pipeline and returns results through a shared result FIFO with valid/ready back-pressure.
- Sits between decode/issue front-ends (scalar core, vector lanes) and the float datapath built on the fpu package types.

---
 rtl/fpu_share_arbiter.sv | 114 +++++++++++
 tb/tb_fpu_share_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one pipelined FPU with tagged in-order result FIFO.
// Define FPU_ARB_PRIORITY0_EN to give requester 0 strict priority over the round-robin group.
module fpu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [2*NUM_REQ-1:0]   req_op,
  input  logic [2*NUM_REQ-1:0]   req_round,
  output logic                   unit_valid,
  output logic [31:0]            unit_a,
  output logic [31:0]            unit_b,
  output logic [1:0]             unit_op,
  output logic [1:0]             unit_round,
  input  logic                   unit_result_valid,
  input  logic [31:0]            unit_result,
  input  logic [4:0]             unit_flags,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IW-1:0]          resp_id,
  output logic [31:0]            resp_result,
  output logic [4:0]             resp_flags,
  output logic                   err
);
`ifdef FPU_ARB_PRIORITY0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  logic [IW-1:0] ptr_q, ptr_d, gnt_id;
  logic [IW:0] idx;
  logic gnt_v, push, pop, full, err_q;
  logic [CW-1:0] cred_q, cred_d, cnt_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [IW+36:0] mem_q [FIFO_DEPTH];
  logic [LATENCY-1:0] tv_q;
  logic [IW-1:0] tid_q [LATENCY];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    gnt_v = 1'b0;
    gnt_id = '0;
    idx = '0;
    if (rst && cred_q != '0) begin
      if (PRIO && req_valid[0]) gnt_v = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = {1'b0, ptr_q} + (IW+1)'(k);
        if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
        if (!gnt_v && req_valid[idx[IW-1:0]]) begin
          gnt_v = 1'b1;
          gnt_id = idx[IW-1:0];
        end
      end
    end
  end

  assign req_ready  = gnt_v ? NUM_REQ'(1) << gnt_id : '0;
  assign unit_valid = gnt_v;
  assign unit_a     = gnt_v ? req_a[32*gnt_id +: 32] : '0;
  assign unit_b     = gnt_v ? req_b[32*gnt_id +: 32] : '0;
  assign unit_op    = gnt_v ? req_op[2*gnt_id +: 2] : '0;
  assign unit_round = gnt_v ? req_round[2*gnt_id +: 2] : '0;
  // strict-priority grants to requester 0 leave the round-robin position alone
  assign ptr_d = (gnt_v && !(PRIO && gnt_id == '0)) ?
                 (gnt_id == IW'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1) : ptr_q;
  assign full       = cnt_q == CW'(FIFO_DEPTH);
  assign resp_valid = rst && cnt_q != '0;
  assign pop        = resp_valid && resp_ready;
  assign push       = unit_result_valid && (!full || pop);
  assign cred_d     = cred_q - CW'(gnt_v) + CW'(pop && (cred_q != CW'(FIFO_DEPTH) || gnt_v));
  assign {resp_id, resp_result, resp_flags} = mem_q[rd_q];
  assign err = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q  <= '0;
      cred_q <= CW'(FIFO_DEPTH);
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      tv_q   <= '0;
      err_q  <= 1'b0;
      for (int k = 0; k < LATENCY; k++) tid_q[k] <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cred_q <= cred_d;
      cnt_q  <= cnt_q + CW'(push) - CW'(pop);
      if (push) begin
        mem_q[wr_q] <= {tid_q[LATENCY-1], unit_result, unit_flags};
        wr_q <= nxt(wr_q);
      end
      if (pop) rd_q <= nxt(rd_q);
      for (int k = LATENCY - 1; k > 0; k--) begin
        tv_q[k]  <= tv_q[k-1];
        tid_q[k] <= tid_q[k-1];
      end
      tv_q[0]  <= gnt_v;
      tid_q[0] <= gnt_id;
      err_q <= err_q || (tv_q[LATENCY-1] != unit_result_valid) || (unit_result_valid && full && !pop);
    end
  end
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb_fpu_share_arbiter: vector table with result scoreboard, ideal-unit model and corner sequences.
module tb_fpu_share_arbiter;
  localparam int N = 2, LAT = 3;
`ifdef FPU_ARB_PRIORITY0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  typedef struct { logic [1:0] rv; logic rr; logic [1:0] rdy; logic [1:0] rdyp; logic rsp; } vec_t;
  typedef struct { logic [0:0] id; logic [31:0] res; logic [4:0] flg; } exp_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [32*N-1:0] req_a = '0, req_b = '0;
  logic [2*N-1:0] req_op = '0, req_round = '0;
  logic unit_valid, unit_result_valid, resp_valid, err;
  logic [31:0] unit_a, unit_b, unit_result, resp_result;
  logic [1:0] unit_op, unit_round;
  logic [4:0] unit_flags, resp_flags;
  logic resp_ready = 1'b1;
  logic [0:0] resp_id;
  logic emu_rv = 1'b0, inj = 1'b0, sb_en = 1'b1;
  logic [31:0] emu_res = '0;
  logic [4:0] emu_flg = '0;
  vec_t tbl[$];
  exp_t sbq[$];
  exp_t e;
  logic [1:0] er;
  logic [0:0] eid;
  int nvec = 0, nbad = 0;

  assign unit_result_valid = emu_rv | inj;
  assign unit_result = emu_res;
  assign unit_flags = emu_flg;

  fpu_share_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_round(req_round),
    .unit_valid(unit_valid), .unit_a(unit_a), .unit_b(unit_b), .unit_op(unit_op),
    .unit_round(unit_round), .unit_result_valid(unit_result_valid), .unit_result(unit_result),
    .unit_flags(unit_flags), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result), .resp_flags(resp_flags), .err(err));

  always #5 clk = ~clk;

  function automatic logic [31:0] fres(logic [31:0] a, logic [31:0] b, logic [1:0] op, logic [1:0] rnd);
    return a + (b << 1) + {28'h0, op, rnd};
  endfunction
  function automatic logic [4:0] fflg(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    return a[4:0] ^ b[4:0] ^ {3'b0, op};
  endfunction
  function automatic logic [31:0] a_of(int v, int i); return 32'((i + 1) << 28) + 32'(v); endfunction
  function automatic logic [31:0] b_of(int v, int i); return 32'(v * 256 + i * 7 + 3); endfunction
  function automatic logic [1:0] op_of(int v, int i); return 2'(v + i); endfunction
  function automatic logic [1:0] rd_of(int v, int i); return 2'(3 * v + i); endfunction

  task automatic add(int n, logic [1:0] rv, logic rr, logic [1:0] rdy, logic [1:0] rdyp, logic rsp);
    repeat (n) tbl.push_back('{rv, rr, rdy, rdyp, rsp});
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(int v, logic [N-1:0] rv, logic rr);
    @(posedge clk); #1;
    req_valid = rv;
    resp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = a_of(v, i);
      req_b[32*i +: 32] = b_of(v, i);
      req_op[2*i +: 2] = op_of(v, i);
      req_round[2*i +: 2] = rd_of(v, i);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic sb_check();
    if (sb_en && resp_valid && resp_ready) begin
      if (sbq.size() == 0) begin
        nvec++;
        nbad++;
        $display("FAIL sb_empty: got resp_id %0d, expected no response", resp_id);
      end else begin
        e = sbq.pop_front();
        chk("resp_id", 64'(resp_id), 64'(e.id));
        chk("resp_result", 64'(resp_result), 64'(e.res));
        chk("resp_flags", 64'(resp_flags), 64'(e.flg));
      end
    end
  endtask

  // ideal fixed-latency execution unit: result appears LAT cycles after issue
  initial begin : emu
    logic pv [LAT];
    logic [31:0] pr [LAT];
    logic [4:0] pf [LAT];
    logic cv;
    logic [31:0] cr;
    logic [4:0] cf;
    for (int k = 0; k < LAT; k++) begin
      pv[k] = 1'b0;
      pr[k] = '0;
      pf[k] = '0;
    end
    forever begin
      @(negedge clk);
      cv = unit_valid;
      cr = fres(unit_a, unit_b, unit_op, unit_round);
      cf = fflg(unit_a, unit_b, unit_op);
      @(posedge clk); #1;
      for (int k = LAT - 1; k > 0; k--) begin
        pv[k] = pv[k-1];
        pr[k] = pr[k-1];
        pf[k] = pf[k-1];
      end
      pv[0] = cv;
      pr[0] = cr;
      pf[0] = cf;
      emu_rv = pv[LAT-1];
      emu_res = pr[LAT-1];
      emu_flg = pf[LAT-1];
    end
  end

  initial begin : main
    // rv, resp_ready, ready (round-robin), ready (priority-0 build), resp_valid
    add(1, 2'b11, 1, 2'b01, 2'b01, 0);
    add(1, 2'b11, 1, 2'b10, 2'b01, 0);
    add(1, 2'b11, 1, 2'b01, 2'b01, 0);
    add(1, 2'b11, 1, 2'b10, 2'b01, 0);
    add(1, 2'b11, 1, 2'b00, 2'b00, 1);
    add(1, 2'b11, 1, 2'b01, 2'b01, 1);
    add(1, 2'b11, 1, 2'b10, 2'b01, 1);
    add(1, 2'b11, 1, 2'b01, 2'b01, 1);
    add(1, 2'b00, 1, 2'b00, 2'b00, 0);
    add(3, 2'b00, 1, 2'b00, 2'b00, 1);
    add(1, 2'b01, 1, 2'b01, 2'b01, 0);
    add(1, 2'b10, 1, 2'b10, 2'b10, 0);
    add(2, 2'b00, 1, 2'b00, 2'b00, 0);
    add(2, 2'b00, 1, 2'b00, 2'b00, 1);
    add(1, 2'b00, 1, 2'b00, 2'b00, 0);
    add(4, 2'b10, 0, 2'b10, 2'b10, 0);
    add(4, 2'b10, 0, 2'b00, 2'b00, 1);
    add(1, 2'b10, 1, 2'b00, 2'b00, 1);
    add(1, 2'b10, 0, 2'b10, 2'b10, 1);
    add(3, 2'b10, 0, 2'b00, 2'b00, 1);
    add(4, 2'b00, 1, 2'b00, 2'b00, 1);
    add(1, 2'b00, 1, 2'b00, 2'b00, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive(0, '0, 1);
      @(negedge clk);
      chk("idle_req_ready", 64'(req_ready), 0);
      chk("idle_unit_valid", 64'(unit_valid), 0);
      chk("idle_resp_valid", 64'(resp_valid), 0);
      chk("idle_err", 64'(err), 0);
    end
    for (int v = 0; v < tbl.size(); v++) begin
      er = PRIO ? tbl[v].rdyp : tbl[v].rdy;
      eid = er[1];
      drive(v, tbl[v].rv, tbl[v].rr);
      if (er != 2'b00)
        sbq.push_back('{eid, fres(a_of(v, int'(eid)), b_of(v, int'(eid)), op_of(v, int'(eid)), rd_of(v, int'(eid))),
                       fflg(a_of(v, int'(eid)), b_of(v, int'(eid)), op_of(v, int'(eid)))});
      @(negedge clk);
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("unit_valid", 64'(unit_valid), 64'(er != 2'b00));
      chk("unit_a", 64'(unit_a), 64'(er != 2'b00 ? a_of(v, int'(eid)) : 32'h0));
      chk("resp_valid", 64'(resp_valid), 64'(tbl[v].rsp));
      sb_check();
    end
    chk("sb_drained", 64'(sbq.size()), 0);
    chk("table_err", 64'(err), 0);
    sb_en = 1'b0;
    drive(0, '0, 1);
    inj = 1'b1;
    @(negedge clk);
    chk("err_inject_cycle", 64'(err), 0);
    drive(0, '0, 1);
    inj = 1'b0;
    @(negedge clk);
    chk("err_next", 64'(err), 1);
    for (int c = 0; c < 3; c++) begin
      drive(0, '0, 1);
      @(negedge clk);
      chk("err_sticky", 64'(err), 1);
    end
    reset_pulse();
    @(negedge clk);
    chk("err_cleared", 64'(err), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    for (int w = 0; w < 3; w++) begin
      drive(w, 2'b01, 1);
      @(negedge clk);
      chk("stale_issue", 64'(req_ready), 64'(2'b01));
    end
    reset_pulse();
    @(negedge clk);
    chk("post_rst_resp_valid", 64'(resp_valid), 0);
    chk("post_rst_err", 64'(err), 0);
    chk("post_rst_ready", 64'(req_ready), 0);
    drive(0, '0, 0);
    @(negedge clk);
    chk("stale_err", 64'(err), 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
